// File: rtl/pool2x2_stream_ctrl.sv
// pool2x2_stream_ctrl
// Streaming 2x2 stride-1 average pooling sequencer for a raster-scanned
// feature map whose size is set at runtime. One previous row of pixels is held
// in a line buffer. Every overlapping 2x2 window is reduced to its truncated
// average and sent out on a valid/ready stream.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               frame start pulse, only looked at while idle
//   cfg_cols, cfg_rows  frame width / height, latched on a legal start
//   in_valid/in_ready   input pixel handshake, in_data is the pixel
//   out_valid/out_ready result handshake, out_data is the average
//   out_last            result belongs to the final window of the frame
//   busy                a frame is in progress (RUN or DRAIN)
//   frame_done          pulses on the cycle the last result is accepted
//   cfg_err             sticky flag for a rejected configuration
module pool2x2_stream_ctrl #(
    parameter int DATA_W   = 8,
    parameter int MAX_COLS = 64,
    parameter int DIM_W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic [DIM_W-1:0]  cols_q, rows_q;
    logic [DIM_W-1:0]  col, row;
    logic [DATA_W-1:0] left, up_left, up;
    logic [DATA_W-1:0] line_buf [MAX_COLS];
    logic [DATA_W+1:0] sum;
    logic              cfg_legal, start_ok;
    logic              in_xfer, out_xfer;
    logic              last_pixel, make_result;

    assign cfg_legal = (cfg_cols >= DIM_W'(2)) &&
                       (cfg_cols <= DIM_W'(MAX_COLS)) &&
                       (cfg_rows >= DIM_W'(2));
    assign start_ok  = (state == IDLE) && start && cfg_legal;

    // A new pixel is taken only when the output register is free or is
    // being emptied on this same edge, so a result is never overwritten.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign last_pixel  = (row == rows_q - DIM_W'(1)) && (col == cols_q - DIM_W'(1));
    assign make_result = in_xfer && (row != '0) && (col != '0);

    // The "up" pixel is read from the line buffer before this cycle's write
    // replaces it with the current pixel.
    assign up  = line_buf[col[AW-1:0]];
    assign sum = {2'b00, up_left} + {2'b00, up} + {2'b00, left} + {2'b00, in_data};

    assign busy       = (state != IDLE);
    assign frame_done = (state == DRAIN) && out_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (in_xfer && last_pixel) state_next = DRAIN;
            DRAIN:   if (out_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame geometry and raster position; cfg inputs are ignored mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_q <= '0;
            rows_q <= '0;
            col    <= '0;
            row    <= '0;
        end else if (start_ok) begin
            cols_q <= cfg_cols;
            rows_q <= cfg_rows;
            col    <= '0;
            row    <= '0;
        end else if (in_xfer) begin
            if (col == cols_q - DIM_W'(1)) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            cfg_err <= !cfg_legal;
        end
    end

    // left is the previous pixel of this row and up_left is the up value
    // read on that same transfer, i.e. line_buf[col-1] before it was
    // overwritten. Both are garbage at col 0, where no result is formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left    <= '0;
            up_left <= '0;
        end else if (in_xfer) begin
            left    <= in_data;
            up_left <= up;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            line_buf[col[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (make_result) begin
            out_valid <= 1'b1;
            out_data  <= DATA_W'(sum >> 2);
            out_last  <= last_pixel;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule
